// File: rtl/ball_wall_reflector.sv
// Sequential wall-reflection engine: normalise heading, reflect off contacted walls in order, damp speed.
// Define BOUNCE_COUNT_EN to build the per-ball bounce counters; otherwise bounce_count_out is tied to 0.
module ball_wall_reflector #(
  parameter int NUM_BALLS  = 4,
  parameter int ID_W       = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1,
  parameter int ANGLE_W    = 16,
  parameter int FULL_TURN  = 360,
  parameter int SPEED_W    = 12,
  parameter int DAMP_SHIFT = 3,
  parameter int MIN_SPEED  = 4,
  parameter int CNT_W      = 8
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               in_valid_in,
  output logic               in_ready_out,
  input  logic [ID_W-1:0]    ball_id_in,
  input  logic [ANGLE_W-1:0] dir_in,
  input  logic [SPEED_W-1:0] speed_in,
  input  logic [3:0]         wall_mask_in,
  output logic               out_valid_out,
  input  logic               out_ready_in,
  output logic [ID_W-1:0]    ball_id_out,
  output logic [ANGLE_W-1:0] dir_out,
  output logic [SPEED_W-1:0] speed_out,
  output logic               hit_out,
  output logic [CNT_W-1:0]   bounce_count_out
);

  // state   | meaning
  // S_IDLE  | ready for a request
  // S_NORM  | subtract FULL_TURN until the heading is in range
  // S_WALL  | test/reflect wall wall_idx (0..3), one per cycle
  // S_DAMP  | apply impact loss, update counter, load outputs
  // S_OUT   | hold result until consumer accepts
  typedef enum logic [2:0] {S_IDLE, S_NORM, S_WALL, S_DAMP, S_OUT} state_t;

  localparam int AW = ANGLE_W + 1;
  localparam logic [AW-1:0] FT   = AW'(FULL_TURN);
  localparam logic [AW-1:0] HALF = AW'(FULL_TURN / 2);
  localparam logic [AW-1:0] QTR  = AW'(FULL_TURN / 4);
  localparam logic [AW-1:0] QTR3 = AW'(3 * (FULL_TURN / 4));

  state_t             state;
  logic [AW-1:0]      dir_r;
  logic [SPEED_W-1:0] speed_r;
  logic [3:0]         mask_r;
  logic [ID_W-1:0]    id_r;
  logic [1:0]         wall_idx;
  logic               hit_r;

  logic               toward;
  logic [AW-1:0]      dir_refl;
  logic [SPEED_W-1:0] speed_sub;
  logic [SPEED_W-1:0] speed_damped;

  always_comb begin
    toward = 1'b0;
    case (wall_idx)
      2'd0:    toward = mask_r[0] && ((dir_r < QTR) || (dir_r > QTR3));
      2'd1:    toward = mask_r[1] && (dir_r != '0) && (dir_r < HALF);
      2'd2:    toward = mask_r[2] && (dir_r > QTR) && (dir_r < QTR3);
      default: toward = mask_r[3] && (dir_r > HALF);
    endcase
    dir_refl = dir_r;
    // even index = x-wall (mirror about the y axis), odd = y-wall (negate heading)
    if (!wall_idx[0])
      dir_refl = (dir_r <= HALF) ? (HALF - dir_r) : (HALF + FT - dir_r);
    else
      dir_refl = (dir_r == '0) ? '0 : (FT - dir_r);
  end

  always_comb begin
    speed_sub    = speed_r - (speed_r >> DAMP_SHIFT);
    speed_damped = (speed_sub < SPEED_W'(MIN_SPEED)) ? '0 : speed_sub;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state         <= S_IDLE;
      in_ready_out  <= 1'b1;
      out_valid_out <= 1'b0;
      hit_out       <= 1'b0;
      dir_out       <= '0;
      speed_out     <= '0;
      ball_id_out   <= '0;
      dir_r         <= '0;
      speed_r       <= '0;
      mask_r        <= '0;
      id_r          <= '0;
      wall_idx      <= '0;
      hit_r         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid_in && in_ready_out) begin
            dir_r        <= {1'b0, dir_in};
            speed_r      <= speed_in;
            mask_r       <= wall_mask_in;
            id_r         <= ball_id_in;
            in_ready_out <= 1'b0;
            state        <= S_NORM;
          end
        end
        S_NORM: begin
          if (dir_r >= FT) begin
            dir_r <= dir_r - FT;
          end else begin
            wall_idx <= '0;
            hit_r    <= 1'b0;
            state    <= S_WALL;
          end
        end
        S_WALL: begin
          if (toward) begin
            dir_r <= dir_refl;
            hit_r <= 1'b1;
          end
          wall_idx <= wall_idx + 2'd1;
          if (wall_idx == 2'd3) state <= S_DAMP;
        end
        S_DAMP: begin
          dir_out       <= dir_r[ANGLE_W-1:0];
          speed_out     <= hit_r ? speed_damped : speed_r;
          hit_out       <= hit_r;
          ball_id_out   <= id_r;
          out_valid_out <= 1'b1;
          state         <= S_OUT;
        end
        S_OUT: begin
          if (out_ready_in) begin
            out_valid_out <= 1'b0;
            in_ready_out  <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BOUNCE_COUNT_EN
  logic [CNT_W-1:0] cnt [NUM_BALLS];
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_next;

  assign cnt_cur  = cnt[id_r];
  assign cnt_next = (hit_r && (cnt_cur != '1)) ? cnt_cur + 1'b1 : cnt_cur;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_BALLS; i++) cnt[i] <= '0;
      bounce_count_out <= '0;
    end else if (state == S_DAMP) begin
      cnt[id_r]        <= cnt_next;
      bounce_count_out <= cnt_next;
    end
  end
`else
  assign bounce_count_out = '0;
`endif

endmodule

// File: tb/tb_ball_wall_reflector.sv
// Randomised bench for ball_wall_reflector with an arithmetic reference model and per-cycle checking.
module tb_ball_wall_reflector;

  localparam int NB  = 4;
  localparam int IDW = 2;
  localparam int AW  = 16;
  localparam int FT  = 360;
  localparam int SW  = 12;
  localparam int DS  = 3;
  localparam int MS  = 4;
  localparam int CW  = 8;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef BOUNCE_COUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic           clk_in = 1'b0;
  logic           rst_n_in;
  logic           in_valid_in;
  logic           in_ready_out;
  logic [IDW-1:0] ball_id_in;
  logic [AW-1:0]  dir_in;
  logic [SW-1:0]  speed_in;
  logic [3:0]     wall_mask_in;
  logic           out_valid_out;
  logic           out_ready_in;
  logic [IDW-1:0] ball_id_out;
  logic [AW-1:0]  dir_out;
  logic [SW-1:0]  speed_out;
  logic           hit_out;
  logic [CW-1:0]  bounce_count_out;

  ball_wall_reflector #(
    .NUM_BALLS(NB), .ID_W(IDW), .ANGLE_W(AW), .FULL_TURN(FT), .SPEED_W(SW),
    .DAMP_SHIFT(DS), .MIN_SPEED(MS), .CNT_W(CW)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .in_valid_in(in_valid_in), .in_ready_out(in_ready_out),
    .ball_id_in(ball_id_in), .dir_in(dir_in), .speed_in(speed_in), .wall_mask_in(wall_mask_in),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
    .ball_id_out(ball_id_out), .dir_out(dir_out), .speed_out(speed_out),
    .hit_out(hit_out), .bounce_count_out(bounce_count_out)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: reduce heading modulo a turn, then reflect as angle arithmetic modulo a turn.
  function automatic void model(input int dir, input int spd, input int mask,
                                output int d_o, output int s_o, output int h_o, output int k_o);
    int d;
    int s;
    int h;
    bit tw;
    d = dir % FT;
    k_o = dir / FT;
    s = spd;
    h = 0;
    for (int w = 0; w < 4; w++) begin
      if (((mask >> w) & 1) == 1) begin
        case (w)
          0: tw = (d < FT/4) || (d > 3*FT/4);
          1: tw = (d > 0) && (d < FT/2);
          2: tw = (d > FT/4) && (d < 3*FT/4);
          default: tw = (d > FT/2);
        endcase
        if (tw) begin
          d = (w % 2 == 0) ? ((FT/2 - d + FT) % FT) : ((FT - d) % FT);
          h = 1;
        end
      end
    end
    if (h == 1) begin
      s = s - s / (1 << DS);
      if (s < MS) s = 0;
    end
    d_o = d;
    s_o = s;
    h_o = h;
  endfunction

  longint cyc = 0;
  bit     in_rst = 1'b1;
  bit     pend = 1'b0;
  bit     seen_valid = 1'b0;
  longint due = 0;
  longint acc_cyc = 0;
  int     e_id, e_dir, e_spd, e_hit, e_cnt, e_k;
  int     cnt_m [NB];
  int     last_dir, last_spd, last_hit, last_cnt, last_lat;

  always @(posedge clk_in) begin
    cyc++;
    if (!rst_n_in) begin
      in_rst = 1'b1;
      pend = 1'b0;
      for (int i = 0; i < NB; i++) cnt_m[i] = 0;
    end else begin
      in_rst = 1'b0;
      if (out_valid_out && out_ready_in) begin
        pend = 1'b0;
        last_dir = int'(dir_out);
        last_spd = int'(speed_out);
        last_hit = int'(hit_out);
        last_cnt = int'(bounce_count_out);
      end
      if (in_valid_in && in_ready_out) begin
        model(int'(dir_in), int'(speed_in), int'(wall_mask_in), e_dir, e_spd, e_hit, e_k);
        e_id = int'(ball_id_in);
        if (e_hit == 1 && cnt_m[e_id] < CNT_MAX) cnt_m[e_id]++;
        e_cnt = (CNT_ON == 1) ? cnt_m[e_id] : 0;
        pend = 1'b1;
        seen_valid = 1'b0;
        acc_cyc = cyc;
        due = cyc + e_k + 6;
      end
    end
  end

  always @(negedge clk_in) begin
    if (cyc > 0) begin
      if (in_rst) begin
        chk("rst_ready", in_ready_out, 1);
        chk("rst_outs", {out_valid_out, hit_out, ball_id_out, dir_out, speed_out, bounce_count_out}, 0);
      end else begin
        chk("in_ready", in_ready_out, !pend);
        chk("out_valid", out_valid_out, pend && (cyc >= due));
        if (pend && cyc >= due) begin
          chk("out_id", ball_id_out, e_id);
          chk("out_dir", dir_out, e_dir);
          chk("out_speed", speed_out, e_spd);
          chk("out_hit", hit_out, e_hit);
          chk("out_count", bounce_count_out, e_cnt);
          if (!seen_valid) begin
            seen_valid = 1'b1;
            last_lat = int'(cyc - acc_cyc);
          end
        end
      end
    end
  end

  task automatic send(input int id, input int dir, input int spd, input int mask, input int rdy_dly);
    int b;
    @(negedge clk_in);
    ball_id_in   = IDW'(id);
    dir_in       = AW'(dir);
    speed_in     = SW'(spd);
    wall_mask_in = 4'(mask);
    in_valid_in  = 1'b1;
    out_ready_in = (rdy_dly < 0);
    b = 0;
    while (in_ready_out !== 1'b1 && b < 50) begin
      @(negedge clk_in);
      b++;
    end
    if (b >= 50) begin
      chk("accept_timeout", 1, 0);
      in_valid_in = 1'b0;
      return;
    end
    @(negedge clk_in);
    in_valid_in  = 1'b0;
    ball_id_in   = IDW'($urandom);
    dir_in       = AW'($urandom);
    speed_in     = SW'($urandom);
    wall_mask_in = 4'($urandom);
    b = 0;
    while (out_valid_out !== 1'b1 && b < 400) begin
      @(negedge clk_in);
      b++;
    end
    if (b >= 400) begin
      chk("valid_timeout", 1, 0);
      out_ready_in = 1'b0;
      return;
    end
    if (rdy_dly > 0) repeat (rdy_dly) @(negedge clk_in);
    out_ready_in = 1'b1;
    @(negedge clk_in);
    out_ready_in = 1'b0;
  endtask

  int md, ms, mh, mk;

  initial begin
    rst_n_in = 1'b0;
    in_valid_in = 1'b0;
    out_ready_in = 1'b0;
    ball_id_in = '0;
    dir_in = '0;
    speed_in = '0;
    wall_mask_in = '0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;

    model(45, 100, 1, md, ms, mh, mk);
    chk("model_45", {32'(md), 32'(ms)}, {32'd135, 32'd88});
    model(30, 88, 3, md, ms, mh, mk);
    chk("model_corner", {32'(md), 32'(ms)}, {32'd210, 32'd77});
    model(800, 3, 2, md, ms, mh, mk);
    chk("model_norm", {32'(md), 32'(ms), 32'(mk)}, {32'd280, 32'd0, 32'd2});
    model(90, 50, 1, md, ms, mh, mk);
    chk("model_parallel", {32'(md), 32'(mh)}, {32'd90, 32'd0});

    send(1, 45, 100, 1, 0);
    chk("t1_dir", last_dir, 135);
    chk("t1_speed", last_spd, 88);
    chk("t1_hit", last_hit, 1);
    chk("t1_count", last_cnt, CNT_ON);
    chk("t1_latency", last_lat, 6);

    send(1, 30, 88, 3, -1);
    chk("corner_dir", last_dir, 210);
    chk("corner_speed", last_spd, 77);
    chk("corner_count", last_cnt, 2 * CNT_ON);

    send(1, 135, 50, 1, 0);
    chk("away_dir", last_dir, 135);
    chk("away_hit", last_hit, 0);
    chk("away_count", last_cnt, 2 * CNT_ON);

    send(0, 90, 50, 1, 0);
    chk("parallel_dir", last_dir, 90);
    chk("parallel_speed", last_spd, 50);

    send(3, 800, 3, 2, 0);
    chk("norm_dir", last_dir, 280);
    chk("norm_speed", last_spd, 0);
    chk("norm_latency", last_lat, 8);

    send(2, 200, 500, 4, 5);
    chk("bp_dir", last_dir, 340);

    repeat (150) begin
      int sel;
      int dir;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: dir = int'($urandom_range(0, 719));
        1: dir = 90 * int'($urandom_range(0, 7));
        2: dir = int'($urandom_range(0, 65535));
        default: dir = int'($urandom_range(0, 2000));
      endcase
      send(int'($urandom_range(0, NB-1)), dir, int'($urandom_range(0, 4095)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 5)) - 1);
    end

    // abort a request mid-normalisation
    @(negedge clk_in);
    ball_id_in = 2'd1;
    dir_in = 16'd1000;
    speed_in = 12'd99;
    wall_mask_in = 4'b0001;
    in_valid_in = 1'b1;
    @(negedge clk_in);
    in_valid_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (12) @(negedge clk_in);
    for (int i = 0; i < NB; i++) begin
      send(i, 45, 100, 0, 0);
      chk("post_rst_count", last_cnt, 0);
    end

    repeat (260) send(2, 45, int'($urandom_range(0, 4095)), 1, 0);
    chk("sat_count", last_cnt, CNT_MAX * CNT_ON);
    for (int i = 0; i < NB; i++) begin
      send(i, 45, 100, 0, 0);
      chk("sat_other", last_cnt, (i == 2) ? CNT_MAX * CNT_ON : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ball_wall_reflector.md
# ball_wall_reflector

Sequential, parametrised wall-reflection engine for the ball physics path. Accepts one collision request at a time (ball ID, heading, speed, mask of walls contacted) over a valid/ready handshake. Normalises the heading, applies each contacted wall's reflection in a fixed order (so corner hits resolve correctly), damps speed on impact, and tracks per-ball bounce counts. Sits between collision detection and the ball position integrator.

## Interface
- NUM_BALLS, 4, number of ball channels; ID_W = $clog2(NUM_BALLS), minimum 1
- ANGLE_W, 16, heading width in units (degrees by default)
- FULL_TURN, 360, units per revolution; must be a multiple of 4; HALF = FULL_TURN/2, Q = FULL_TURN/4
- SPEED_W, 12, speed width
- DAMP_SHIFT, 3, impact loss is speed >> DAMP_SHIFT
- MIN_SPEED, 4, post-damp speed below this is forced to 0
- CNT_W, 8, bounce counter width
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, synchronous, active-low
- in_valid_in  input  1  request valid
- in_ready_out  output  1  block can accept a request
- ball_id_in  input  ID_W  ball channel
- dir_in  input  ANGLE_W  heading, 0 = +x, counter-clockwise, any value up to 2^ANGLE_W-1
- speed_in  input  SPEED_W  speed magnitude
- wall_mask_in  input  4  contacted walls: bit0 +x, bit1 +y, bit2 -x, bit3 -y
- out_valid_out  output  1  result valid
- out_ready_in  input  1  consumer accepts result
- ball_id_out  output  ID_W  echoed ball ID
- dir_out  output  ANGLE_W  new heading, in [0, FULL_TURN)
- speed_out  output  SPEED_W  new speed
- hit_out  output  1  at least one reflection applied
- bounce_count_out  output  CNT_W  this ball's bounce count after this request

## Operation
- FSM states: IDLE, NORM, WALL, DAMP, OUT.
- IDLE: in_ready_out=1. in_valid_in && in_ready_out captures all inputs; go to NORM.
- NORM: each cycle, if dir >= FULL_TURN then dir -= FULL_TURN and stay; otherwise clear wall index and hit, go to WALL.
- WALL: one cycle per wall index 0..3, always 4 cycles. Reflect only if the mask bit is set and the ball moves toward that wall:
  - +x toward: d<Q or d>3Q. +y: 0<d<HALF. -x: Q<d<3Q. -y: d>HALF.
  - x-walls: d' = HALF-d if d<=HALF, else HALF+FULL_TURN-d.
  - y-walls: d' = FULL_TURN-d, with 0 mapping to 0.
  - Heading exactly parallel to the wall is not toward it and is left unchanged.
  - Each applied reflection sets hit. Later walls test the already-updated heading.
- DAMP, 1 cycle:
  - If hit: speed -= speed>>DAMP_SHIFT; if the result is below MIN_SPEED, speed=0; that ball's counter increments, saturating at 2^CNT_W-1.
  - If no hit: speed and counter unchanged.
- OUT: out_valid_out=1 with all result outputs held stable until out_ready_in. The handshake completes the transfer and the FSM returns to IDLE.
- in_ready_out=0 in every state except IDLE. No request overlaps another.

## Timing
- Reset values: in_ready_out=1 (first cycle after reset release); out_valid_out=0, hit_out=0, dir_out=0, speed_out=0, ball_id_out=0, bounce_count_out=0; all counters 0; state IDLE.
- Latency: for k = floor(dir_in/FULL_TURN), out_valid_out rises k+6 cycles after the accepting edge; k=0 gives 6.
- Throughput: next acceptance at the earliest 1 cycle after the output handshake, i.e. in_ready_out high the cycle after out handshake.
- out_ready_in may already be high when out_valid_out rises; the handshake then completes on that first edge.
- Reset asserted in any state: the in-flight request is discarded without output, counters clear, and all outputs take reset values on the next edge.
- Arithmetic is unsigned and computed at ANGLE_W+1 bits internally, so no intermediate wraps.

## Configuration
- BOUNCE_COUNT_EN defined: per-ball counters are synthesised and bounce_count_out reports them.
- BOUNCE_COUNT_EN undefined: no counters are built and bounce_count_out is constant 0. All other behaviour and timing are identical.

## Test plan
- dir 45, mask 0001, speed 100 -> dir 135, speed 88, hit 1, count 1, out_valid_out 6 cycles after acceptance.
- Corner: dir 30, mask 0011, speed 88 -> +x gives 150, then +y gives 210; speed 77, hit 1.
- Non-toward: dir 135, mask 0001, speed 50 -> dir 135, speed 50, hit 0, count unchanged. Also dir 90, mask 0001 (parallel) -> unchanged.
- Normalisation and stop: dir 800, mask 0010, speed 3 -> dir 80 becomes 280, speed 0, out_valid_out at cycle 8.
- Backpressure and reset: hold out_ready_in low 5 cycles -> outputs stable and in_ready_out 0 throughout. Then assert rst_n_in=0 during NORM of a new request -> no output, counters read 0 afterwards.
- Saturation, with BOUNCE_COUNT_EN: 260 hits on ball 2 -> count 255, other balls 0. Without the macro: count 0 always.
